// File: rtl/board_action_ctrl.sv
// Turns mouse clicks on a board cell into defuse / flag / explode requests for the redraw datapath.
// Latency: button edge -> CAPTURE -> ISSUE -> request registered on the third edge; ack ends it on the next edge.
// Backpressure: one action in flight; new clicks are ignored until the ack (or timeout) and full button release.
module board_action_ctrl #(
    parameter int ACK_TIMEOUT = 15,
    parameter int MOVE_MAX    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] level,
    input  logic       game_start,
    input  logic       left_btn,
    input  logic       right_btn,
    input  logic [4:0] cell_x,
    input  logic [4:0] cell_y,
    input  logic       cell_valid,
    input  logic       mine_here,
    input  logic       flag_here,
    input  logic       defused_here,
    input  logic       game_won,
    input  logic       upd_ack,
    output logic [4:0] sym_ind_x,
    output logic [4:0] sym_ind_y,
    output logic       defuse,
    output logic       mark_flag,
    output logic       explode,
    output logic       busy,
    output logic       game_over,
    output logic [9:0] move_cnt
);

    typedef enum logic [2:0] {
        IDLE, ARMED, CAPTURE, ISSUE, WAIT_ACK, RELEASE, LOST, WON
    } state_t;

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [9:0]    CNT_MAX  = 10'(MOVE_MAX);

    state_t        state_q, state_d;
    logic          left_q, right_q;
    logic          act_right_q, act_right_d;
    logic [4:0]    sym_x_q, sym_x_d, sym_y_q, sym_y_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [9:0]    cnt_q, cnt_d;

    logic       left_rise, right_rise, in_range;
    logic [4:0] board_size;

    assign left_rise  = left_btn & ~left_q;
    assign right_rise = right_btn & ~right_q;

    // Board dimension for the current level; the invalid level yields size 0 so nothing is in range
    always_comb begin
        board_size = 5'd0;
        case (level)
            2'b00:   board_size = 5'd8;
            2'b01:   board_size = 5'd10;
            2'b10:   board_size = 5'd16;
            default: board_size = 5'd0;
        endcase
    end

    assign in_range = cell_valid && (cell_x < board_size) && (cell_y < board_size);

    // State, latched target, timeout counter, move count and button history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            act_right_q <= 1'b0;
            sym_x_q     <= 5'd0;
            sym_y_q     <= 5'd0;
            tmo_q       <= '0;
            cnt_q       <= 10'd0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_btn;
            right_q     <= right_btn;
            act_right_q <= act_right_d;
            sym_x_q     <= sym_x_d;
            sym_y_q     <= sym_y_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic; game_start overrides everything and begins a fresh game
    always_comb begin
        state_d     = state_q;
        act_right_d = act_right_q;
        sym_x_d     = sym_x_q;
        sym_y_d     = sym_y_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        if (game_start) begin
            state_d = ARMED;
            tmo_d   = '0;
            cnt_d   = 10'd0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (game_won) begin
                        state_d = WON;
                    end else if ((left_rise || right_rise) && in_range) begin
                        // Left wins a simultaneous press; the right edge is simply dropped
                        state_d     = CAPTURE;
                        act_right_d = ~left_rise;
                        sym_x_d     = cell_x;
                        sym_y_d     = cell_y;
                    end
                end
                CAPTURE: state_d = ISSUE;
                ISSUE: begin
                    tmo_d = '0;
                    if (!act_right_q) begin
                        if (defused_here || flag_here) state_d = RELEASE;
                        else if (mine_here)            state_d = LOST;
                        else                           state_d = WAIT_ACK;
                    end else begin
                        if (defused_here) state_d = RELEASE;
                        else              state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (upd_ack) begin
                        state_d = RELEASE;
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 10'd1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (game_won)              state_d = WON;
                    else if (!left_q && !right_q) state_d = ARMED;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from registered state, so they are glitch-free and reset-clean
    always_comb begin
        defuse    = (state_q == WAIT_ACK) && !act_right_q;
        mark_flag = (state_q == WAIT_ACK) &&  act_right_q;
        explode   = (state_q == LOST);
        busy      = (state_q != ARMED);
        game_over = (state_q == LOST) || (state_q == WON);
        sym_ind_x = sym_x_q;
        sym_ind_y = sym_y_q;
        move_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_board_action_ctrl.sv
// Directed bench for board_action_ctrl with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
// MOVE_MAX is reduced to 3 so move-count saturation can be reached quickly.
module tb_board_action_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] level;
    logic       game_start, left_btn, right_btn;
    logic [4:0] cell_x, cell_y;
    logic       cell_valid, mine_here, flag_here, defused_here, game_won, upd_ack;
    logic [4:0] sym_ind_x, sym_ind_y;
    logic       defuse, mark_flag, explode, busy, game_over;
    logic [9:0] move_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    board_action_ctrl #(.ACK_TIMEOUT(15), .MOVE_MAX(3)) dut (
        .clk(clk), .rst(rst), .level(level), .game_start(game_start),
        .left_btn(left_btn), .right_btn(right_btn), .cell_x(cell_x), .cell_y(cell_y),
        .cell_valid(cell_valid), .mine_here(mine_here), .flag_here(flag_here),
        .defused_here(defused_here), .game_won(game_won), .upd_ack(upd_ack),
        .sym_ind_x(sym_ind_x), .sym_ind_y(sym_ind_y), .defuse(defuse),
        .mark_flag(mark_flag), .explode(explode), .busy(busy),
        .game_over(game_over), .move_cnt(move_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop both buttons and wait (bounded) for the block to re-arm
    task automatic release_and_arm(input string tag);
        int ok;
        ok = 0;
        left_btn  = 1'b0;
        right_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    // One complete acknowledged action at (x,y)
    task automatic click_ack(input logic is_left, input logic [4:0] x, input logic [4:0] y);
        cell_x = x;
        cell_y = y;
        left_btn  = is_left;
        right_btn = ~is_left;
        step(); step(); step();
        upd_ack = 1'b1;
        step();
        upd_ack = 1'b0;
        release_and_arm("click_rearm");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; level = 2'b00; game_start = 1'b0; left_btn = 1'b1; right_btn = 1'b0;
        cell_x = 5'd0; cell_y = 5'd0; cell_valid = 1'b1; mine_here = 1'b0; flag_here = 1'b0;
        defused_here = 1'b0; game_won = 1'b0; upd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_game_over", game_over, 0);
        check("rst_defuse", defuse, 0);
        check("rst_mark_flag", mark_flag, 0);
        check("rst_explode", explode, 0);
        check("rst_move_cnt", move_cnt, 0);
        check("rst_sym_x", sym_ind_x, 0);

        // Button held through reset: nothing happens before game_start
        rst = 1'b1;
        repeat (4) step();
        check("idle_busy", busy, 1);
        check("idle_no_defuse", defuse, 0);

        // Basic left click with a 5-cycle request
        game_start = 1'b1; step(); game_start = 1'b0;
        check("armed_busy", busy, 0);
        step();
        check("held_btn_no_action", busy, 0);
        left_btn = 1'b0; step();
        cell_x = 5'd3; cell_y = 5'd4; left_btn = 1'b1;
        step();
        check("capture_busy", busy, 1);
        step();
        check("issue_no_req", defuse, 0);
        step();
        check("defuse_on", defuse, 1);
        check("sym_x_3", sym_ind_x, 3);
        check("sym_y_4", sym_ind_y, 4);
        n = 1;
        repeat (4) begin
            step();
            n += int'(defuse);
        end
        upd_ack = 1'b1; step(); upd_ack = 1'b0;
        check("defuse_len", n, 5);
        check("defuse_off", defuse, 0);
        check("cnt_after_ack", move_cnt, 1);
        check("release_while_held", busy, 1);
        release_and_arm("rearm_1");

        // Mine hit on 10x10 board
        level = 2'b01; cell_x = 5'd9; cell_y = 5'd9; mine_here = 1'b1; left_btn = 1'b1;
        step(); step();
        check("explode_early", explode, 0);
        step();
        check("explode_on", explode, 1);
        check("lost_game_over", game_over, 1);
        mine_here = 1'b0; left_btn = 1'b0; step(); step();
        cell_x = 5'd1; cell_y = 5'd1; left_btn = 1'b1;
        repeat (4) step();
        check("lost_explode_held", explode, 1);
        check("lost_no_defuse", defuse, 0);
        check("lost_cnt", move_cnt, 1);
        check("lost_sym_frozen", sym_ind_x, 9);
        left_btn = 1'b0; step();
        game_start = 1'b1; step(); game_start = 1'b0;
        check("restart_explode", explode, 0);
        check("restart_game_over", game_over, 0);
        check("restart_cnt", move_cnt, 0);
        check("restart_busy", busy, 0);

        // Out-of-range click, then right click on 16x16 with level change mid-action
        level = 2'b00; cell_x = 5'd8; cell_y = 5'd2; left_btn = 1'b1;
        step();
        check("oob_busy_a", busy, 0);
        step();
        check("oob_busy_b", busy, 0);
        left_btn = 1'b0; step();
        level = 2'b10; cell_x = 5'd15; cell_y = 5'd15; right_btn = 1'b1;
        step();
        level = 2'b00;
        step(); step();
        check("flag_on", mark_flag, 1);
        check("flag_no_defuse", defuse, 0);
        check("flag_sym_x", sym_ind_x, 15);
        upd_ack = 1'b1; step(); upd_ack = 1'b0;
        check("flag_off", mark_flag, 0);
        check("flag_cnt", move_cnt, 1);
        release_and_arm("rearm_2");

        // Both buttons rise together: left wins, holding never retriggers
        cell_x = 5'd2; cell_y = 5'd2; left_btn = 1'b1; right_btn = 1'b1;
        step(); step(); step();
        check("both_defuse", defuse, 1);
        check("both_no_flag", mark_flag, 0);
        upd_ack = 1'b1; step(); upd_ack = 1'b0;
        check("both_cnt", move_cnt, 2);
        n = 0;
        repeat (50) begin
            step();
            if (defuse || mark_flag) n++;
        end
        check("hold_no_retrigger", n, 0);
        check("hold_busy", busy, 1);
        release_and_arm("rearm_3");

        // Left on a flagged cell and right on a defused cell: no request
        flag_here = 1'b1; cell_x = 5'd1; cell_y = 5'd1; left_btn = 1'b1;
        step(); step(); step();
        check("flagged_no_defuse", defuse, 0);
        check("flagged_busy", busy, 1);
        flag_here = 1'b0;
        release_and_arm("rearm_4");
        defused_here = 1'b1; right_btn = 1'b1;
        step(); step(); step();
        check("defused_no_flag", mark_flag, 0);
        defused_here = 1'b0;
        release_and_arm("rearm_5");
        check("skip_cnt", move_cnt, 2);

        // Ack timeout
        cell_x = 5'd5; cell_y = 5'd5; right_btn = 1'b1;
        step(); step(); step();
        check("tmo_flag_on", mark_flag, 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!mark_flag) break;
            n++;
        end
        check("tmo_len", n, 15);
        check("tmo_cnt", move_cnt, 2);
        check("tmo_release", busy, 1);
        release_and_arm("rearm_6");

        // Saturation at MOVE_MAX = 3
        click_ack(1'b1, 5'd0, 5'd0);
        check("sat_cnt_3", move_cnt, 3);
        click_ack(1'b0, 5'd7, 5'd7);
        check("sat_cnt_hold", move_cnt, 3);

        // Asynchronous reset during WAIT_ACK
        cell_x = 5'd6; cell_y = 5'd6; left_btn = 1'b1;
        step(); step(); step();
        check("pre_rst_defuse", defuse, 1);
        #2 rst = 1'b0;
        #1;
        check("async_defuse", defuse, 0);
        check("async_busy", busy, 1);
        check("async_cnt", move_cnt, 0);
        check("async_sym_x", sym_ind_x, 0);
        check("async_game_over", game_over, 0);
        left_btn = 1'b0;
        #2 rst = 1'b1;
        step();
        check("post_rst_idle", busy, 1);

        // Win from ARMED, then leave WON via game_start
        game_start = 1'b1; step(); game_start = 1'b0;
        game_won = 1'b1; step();
        check("won_game_over", game_over, 1);
        check("won_busy", busy, 1);
        game_won = 1'b0; step();
        check("won_stays", game_over, 1);
        game_start = 1'b1; step(); game_start = 1'b0;
        check("won_exit_game_over", game_over, 0);
        check("won_exit_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_action_ctrl.md
BOARD_ACTION_CTRL -- requirements
Module: board_action_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, is the maximum number of cycles spent in WAIT_ACK before the request is abandoned.
REQ-002 Parameter MOVE_MAX, default 1023, is the saturation value of move_cnt.
REQ-003 clk  in  1  the single clock; every flop is rising-edge triggered.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 level  in  2  board size select: 00 = 8x8, 01 = 10x10, 10 = 16x16, 11 = invalid.
REQ-006 game_start  in  1  single-cycle pulse that starts a new game.
REQ-007 left_btn, right_btn  in  1 each  raw mouse button levels: left means defuse, right means flag.
REQ-008 cell_x, cell_y  in  5 each  cursor cell index.
REQ-009 cell_valid  in  1  high while the cursor is inside the board.
REQ-010 mine_here, flag_here, defused_here  in  1 each  combinational lookup at sym_ind_x/sym_ind_y.
REQ-011 game_won  in  1  level from the win checker.
REQ-012 upd_ack  in  1  single-cycle acknowledge from the redraw datapath.
REQ-013 sym_ind_x, sym_ind_y  out  5 each  latched target cell.
REQ-014 defuse, mark_flag, explode  out  1 each  request levels to the redraw datapath.
REQ-015 busy  out  1  high in every state except ARMED.
REQ-016 game_over  out  1  high in LOST or WON.
REQ-017 move_cnt  out  10  count of accepted actions.

Function
REQ-018 The block SHALL implement the states IDLE, ARMED, CAPTURE, ISSUE, WAIT_ACK, RELEASE, LOST and WON, all registered.
REQ-019 The block SHALL register both buttons once and detect rising edges internally; only a 0->1 edge seen in ARMED SHALL start an action.
REQ-020 IDLE -> ARMED SHALL occur on game_start; move_cnt SHALL clear in the same cycle.
REQ-021 In ARMED, a rising edge with cell_valid = 1, a level other than 11, and both cell_x and cell_y below the board size (8, 10 or 16) -> CAPTURE, with sym_ind_x/sym_ind_y latched from cell_x/cell_y; any other edge SHALL be ignored.
REQ-022 If both buttons rise in the same cycle, left SHALL win and the right edge SHALL be discarded.
REQ-023 CAPTURE lasts exactly 1 cycle so the lookup inputs settle; the next state is ISSUE.
REQ-024 ISSUE decision for a left action:
  - defused_here or flag_here -> RELEASE, no request, no count.
  - mine_here -> assert explode, go to LOST.
  - otherwise -> assert defuse, go to WAIT_ACK.
REQ-025 ISSUE decision for a right action:
  - defused_here -> RELEASE, no request.
  - otherwise -> assert mark_flag (this toggles the flag in the datapath), go to WAIT_ACK.
REQ-026 defuse/mark_flag SHALL stay high from ISSUE until the cycle upd_ack is sampled high, and go low on the next edge.
REQ-027 WAIT_ACK SHALL count cycles; if upd_ack is not seen within ACK_TIMEOUT cycles, the request SHALL drop and the state SHALL move to RELEASE without incrementing move_cnt.
REQ-028 On upd_ack, move_cnt SHALL increment, saturating at MOVE_MAX; state -> RELEASE.
REQ-029 RELEASE -> ARMED SHALL occur only when both registered buttons are low; an already-held button SHALL never retrigger an action.
REQ-030 game_won high in ARMED or RELEASE -> WON; explode takes priority over game_won in the same cycle.
REQ-031 explode SHALL remain high for the whole of LOST; sym_ind_x/sym_ind_y SHALL freeze in LOST and WON.
REQ-032 LOST and WON SHALL be left only on game_start, which goes to ARMED with all requests low and move_cnt = 0.
REQ-033 A game_start in any other state SHALL abort the current action, drop all requests and go to ARMED.
REQ-034 A change of level during an action SHALL not alter the action in progress; the bounds check uses the level sampled at the edge.

Reset
REQ-035 On rst low: state = IDLE, sym_ind_x/y = 0, defuse = mark_flag = explode = 0, move_cnt = 0, timeout counter = 0, button registers = 0, busy = 1, game_over = 0.
REQ-036 After rst deasserts, the block SHALL take no action until the first game_start, including when a button is held through reset.

Verification
REQ-037 level = 00, game_start, left at (3,4), mine_here = 0, upd_ack 5 cycles later -> defuse high for 5 cycles, sym_ind = (3,4), move_cnt = 1, state returns to ARMED after the button is released.
REQ-038 level = 01, left at (9,9) with mine_here = 1 -> explode = 1 two cycles after the edge, game_over = 1; further clicks ignored until game_start; game_start -> explode = 0, move_cnt = 0.
REQ-039 level = 00, click at (8,2) -> ignored, busy stays 0; level = 10, right at (15,15), ack after 1 cycle -> mark_flag pulse, move_cnt = 1.
REQ-040 Both buttons rise in one cycle at (2,2) -> defuse only; holding both for 50 cycles produces no second action.
REQ-041 Right click with upd_ack never asserted, ACK_TIMEOUT = 15 -> mark_flag drops after 15 cycles, move_cnt unchanged, state -> RELEASE.
REQ-042 Assert rst in WAIT_ACK -> all outputs return to their reset values immediately; game_won asserted while in ARMED -> WON on the next edge, game_over = 1.
